// File: rtl/sub_chunk_sequencer.sv
// rtl/sub_chunk_sequencer.sv - wide a-b-bin subtractor sequenced over one external 6-bit slice
//
// Purpose:
//   Computes a - b - bin on 6*NCHUNK-bit operands by feeding one 6-bit chunk
//   per cycle (LSB chunk first) to an external combinational ripple-borrow
//   slice, collecting its difference chunks and chaining its borrow.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request, only honoured in IDLE
//   a, b, bin            operands, captured on an accepted start
//   sub_a, sub_b         current operand chunks to the slice (0 outside RUN)
//   sub_bin              running borrow to the slice (0 outside RUN)
//   sub_d, sub_bout      slice difference and borrow-out
//   busy                 high in RUN and DONE
//   done                 one-cycle pulse, results valid from this cycle
//   diff                 W-bit result
//   borrow_out           final borrow (unsigned a < b + bin)
//   zero                 diff == 0
//   ovf                  two's-complement overflow of the subtract

module sub_chunk_sequencer #(
  parameter int NCHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [6*NCHUNK-1:0] a,
  input  logic [6*NCHUNK-1:0] b,
  input  logic                bin,
  output logic [5:0]          sub_a,
  output logic [5:0]          sub_b,
  output logic                sub_bin,
  input  logic [5:0]          sub_d,
  input  logic                sub_bout,
  output logic                busy,
  output logic                done,
  output logic [6*NCHUNK-1:0] diff,
  output logic                borrow_out,
  output logic                zero,
  output logic                ovf
);

  localparam int W    = 6 * NCHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IDXW-1:0] idx;
  logic            brw;
  logic [W-1:0]    diff_nx;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic            accept;
  logic            last_chunk;

  assign accept     = (state == S_IDLE) && start;
  assign last_chunk = (state == S_RUN) && (idx == LAST_IDX);

  // Bring the active chunk down to bit 0 so the slice taps a fixed field.
  assign a_sh = a_q >> (6 * idx);
  assign b_sh = b_q >> (6 * idx);

  // diff with the current slice result merged into the active chunk; this is
  // what diff becomes at the end of the cycle, so the final flags can be
  // registered from it on the RUN->DONE edge.
  always_comb begin
    diff_nx = diff;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        diff_nx[6*i +: 6] = sub_d;
      end
    end
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    sub_a   = 6'd0;
    sub_b   = 6'd0;
    sub_bin = 1'b0;
    case (state)
      S_RUN: begin
        busy    = 1'b1;
        sub_a   = a_sh[5:0];
        sub_b   = b_sh[5:0];
        sub_bin = brw;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // Result and flags are only rewritten during an operation, so they hold
  // across IDLE until the next accepted start overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      brw <= bin;
      idx <= '0;
    end else if (state == S_RUN) begin
      diff <= diff_nx;
      brw  <= sub_bout;
      idx  <= last_chunk ? '0 : idx + IDXW'(1);
      if (last_chunk) begin
        borrow_out <= sub_bout;
        zero       <= (diff_nx == '0);
        // Overflow only possible when operand signs differ; it shows as a
        // result sign that disagrees with the minuend.
        ovf        <= (a_q[W-1] != b_q[W-1]) && (diff_nx[W-1] != a_q[W-1]);
      end
    end
  end

endmodule

// File: doc/sub_chunk_sequencer.md
# sub_chunk_sequencer

Multi-cycle wide subtractor controller that computes `a - b - bin` on operands of `6*NCHUNK` bits by reusing a single external 6-bit ripple-borrow subtractor slice. It sits directly upstream of that slice, presenting one 6-bit operand chunk per cycle (LSB chunk first). It consumes the slice's difference and borrow outputs, accumulating the full-width result and flags. It is the ALU's wide-subtract path, started by the ALU control and reporting completion with a one-cycle `done` pulse.

## Interface
- `NCHUNK`, default 4: number of 6-bit chunks; operand width `W = 6*NCHUNK` (24 at default). Legal range 1..16.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  W  minuend; captured on an accepted `start`.
- `b`  in  W  subtrahend; captured on an accepted `start`.
- `bin`  in  1  borrow-in; captured on an accepted `start`.
- `sub_a`  out  6  chunk of captured `a` driven to the slice.
- `sub_b`  out  6  chunk of captured `b` driven to the slice.
- `sub_bin`  out  1  running borrow driven to the slice.
- `sub_d`  in  6  slice difference (combinational from `sub_a/sub_b/sub_bin`).
- `sub_bout`  in  1  slice borrow-out.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `diff`  out  W  registered result.
- `borrow_out`  out  1  final borrow; 1 means unsigned `a < b + bin`.
- `zero`  out  1  `diff == 0`.
- `ovf`  out  1  two's-complement overflow of the W-bit subtract.

## Operation
- States: IDLE, RUN, DONE. Chunk index `idx` is `ceil(log2(NCHUNK))` bits, minimum 1.
- IDLE:
  - With `start=1`: capture `a`, `b`, `bin` into operand registers; set `idx=0`; set running borrow = `bin`; go to RUN.
  - With `start=0`: stay in IDLE.
- RUN:
  - `sub_a = a_q[6*idx +: 6]`, `sub_b = b_q[6*idx +: 6]`, `sub_bin` = running borrow.
  - Each cycle: `diff[6*idx +: 6] <= sub_d`, running borrow `<= sub_bout`, `idx <= idx+1`.
  - When `idx == NCHUNK-1`, that cycle's update is final and the next state is DONE.
- DONE (one cycle):
  - `done=1`.
  - `borrow_out` = running borrow.
  - `zero = (diff == 0)`.
  - `ovf = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1])`.
  - Return to IDLE.
- Flags are registered on the RUN→DONE edge, or computed from registered values in DONE. In either case they must be valid in the DONE cycle.
- `diff`, `borrow_out`, `zero` and `ovf` hold their values until the next accepted `start`. They are not cleared on the return to IDLE.
- `start` in RUN or DONE is ignored and not queued.
- While not in RUN, `sub_a`, `sub_b` and `sub_bin` drive 0.
- `diff` chunks not yet written in the current operation keep their stale values until overwritten. Only the DONE-cycle value is defined.
- Async reset, at any point including mid-RUN: state IDLE, `idx=0`, all operand registers, `diff`, `borrow_out`, `zero`, `ovf`, `busy`, `done` = 0, `sub_*` = 0. The aborted operation produces no `done`.

## Timing
- `start` accepted at edge E0. RUN occupies cycles 1..NCHUNK. `done=1` in cycle NCHUNK+1, i.e. 5 cycles after the accepting edge at the default NCHUNK.
- `start` is accepted again in the cycle after DONE. Back-to-back throughput is one operation per NCHUNK+2 cycles.
- `busy` rises the cycle after the accepting edge and falls the cycle after DONE.
- The slice path is combinational within a single RUN cycle: `sub_a/sub_b/sub_bin` → `sub_d/sub_bout` → registers. No slice pipeline register is assumed.
- `a`, `b`, `bin` may change freely after the accepting edge.

## Test plan
All scenarios use NCHUNK=4 (W=24) with the 6-bit ripple-borrow slice connected.

1. `a=0x000010`, `b=0x000001`, `bin=0` → `done` 5 cycles after the accepting edge; `diff=0x00000F`, `borrow_out=0`, `zero=0`, `ovf=0`.
2. `a=0x000000`, `b=0x000001`, `bin=0` → `diff=0xFFFFFF`, `borrow_out=1`, `ovf=0`. Additionally check that `sub_bin=1` in RUN cycles 2..4, showing the borrow ripples across chunks.
3. `a=0x123456`, `b=0x123455`, `bin=1` → `diff=0x000000`, `zero=1`, `borrow_out=0`.
4. `a=0x800000`, `b=0x000001`, `bin=0` → `diff=0x7FFFFF`, `ovf=1`, `borrow_out=0`.
5. Hold `start=1` continuously with changing `a`/`b` → only operands present at each IDLE acceptance are used. `done` pulses every 6 cycles, and `busy` stays high throughout RUN and DONE.
6. Assert `rst_n=0` in RUN cycle 2 → all outputs 0 immediately, with no `done` pulse. After release, a new `start` with `a=5`, `b=3` gives `diff=0x000002`.
